// File: rtl/nios_setup_debug_ocimem_ctrl_if.sv
// nios_setup_debug_ocimem_ctrl_if: CPU waitrequest slave port (address/read/write/writedata in, readdata/waitrequest out)
interface nios_setup_debug_ocimem_ctrl_if #(parameter int ADDR_W = 8);
  logic [ADDR_W-1:0] address;
  logic read;
  logic write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic waitrequest;
  modport master(output address, read, write, writedata, input readdata, waitrequest);
  modport slave(input address, read, write, writedata, output readdata, waitrequest);
endinterface

// File: rtl/nios_setup_debug_ocimem_ctrl.sv
// nios_setup_debug_ocimem_ctrl: JTAG/CPU shared debug RAM; ports clk, reset, jdo + ocimem strobes in, MonDReg/monitor_ready/monitor_error out, cpu slave port; NIOS_OCIMEM_AUTOINC_EN enables MonAReg auto-increment
module nios_setup_debug_ocimem_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DEPTH = 256,
  parameter bit INIT_READY = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic [37:0] jdo,
  input  logic take_action_ocimem_a,
  input  logic take_no_action_ocimem_a,
  input  logic take_action_ocimem_b,
  output logic [31:0] MonDReg,
  output logic monitor_ready,
  output logic monitor_error,
  nios_setup_debug_ocimem_ctrl_if.slave cpu
);
`ifdef NIOS_OCIMEM_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  typedef enum logic [2:0] {IDLE, J_RD, J_CAP, J_WR, C_RD} state_t;
  state_t state;
  logic [ADDR_W-1:0] mon_a, rd_addr;
  logic [31:0] mem [DEPTH];
  logic [31:0] ram_q;
  logic c_ok, pend_rd, pend_wr;
  logic sb, sn, any_stb, accept, op_rd, op_wr, cpu_idle, cpu_wr_ok, j_ok, rd_ok, cw_ok;
  logic unused_jdo;
  assign unused_jdo = ^{jdo[37:35], jdo[2:0]};
  always_comb begin
    sb = take_action_ocimem_b & ~take_action_ocimem_a;
    sn = take_no_action_ocimem_a & ~take_action_ocimem_a & ~take_action_ocimem_b;
    any_stb = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    accept = any_stb & monitor_ready;
    op_rd = accept & (take_action_ocimem_a ? jdo[34] : sn);
    op_wr = accept & sb;
    cpu_idle = state == IDLE && !any_stb && !pend_rd && !pend_wr && !reset;
    cpu_wr_ok = cpu_idle & cpu.write & ~cpu.read;
    rd_addr = state == J_RD ? mon_a : cpu.address;
    j_ok = {1'b0, mon_a} < DEPTH_L;
    rd_ok = {1'b0, rd_addr} < DEPTH_L;
    cw_ok = {1'b0, cpu.address} < DEPTH_L;
    cpu.waitrequest = !((cpu_idle && !cpu.read) || (state == C_RD && !reset));
    cpu.readdata = state == C_RD && !reset && c_ok ? ram_q : '0;
  end
  always_ff @(posedge clk) begin
    if (!reset && state == J_WR && j_ok) mem[mon_a[IW-1:0]] <= MonDReg;
    else if (cpu_wr_ok && cw_ok) mem[cpu.address[IW-1:0]] <= cpu.writedata;
    ram_q <= mem[rd_ok ? rd_addr[IW-1:0] : '0];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      mon_a <= '0;
      MonDReg <= '0;
      monitor_ready <= INIT_READY;
      monitor_error <= 1'b0;
      pend_rd <= 1'b0;
      pend_wr <= 1'b0;
      c_ok <= 1'b0;
    end else begin
      if (any_stb && !monitor_ready) monitor_error <= 1'b1;
      if (accept && take_action_ocimem_a) begin
        mon_a <= jdo[ADDR_W+9:10];
        if (jdo[25]) monitor_error <= 1'b0;
      end
      if (op_wr) MonDReg <= jdo[34:3];
      if (op_rd || op_wr) monitor_ready <= 1'b0;
      case (state)
        IDLE: begin
          pend_rd <= 1'b0;
          pend_wr <= 1'b0;
          if (op_rd || pend_rd) state <= J_RD;
          else if (op_wr || pend_wr) state <= J_WR;
          else if (cpu_idle && cpu.read) begin
            state <= C_RD;
            c_ok <= cw_ok;
          end
        end
        J_RD: state <= J_CAP;
        J_CAP: begin
          MonDReg <= j_ok ? ram_q : 32'hDEADBEEF;
          if (!j_ok) monitor_error <= 1'b1;
          if (AUTOINC) mon_a <= mon_a + ADDR_W'(1);
          monitor_ready <= 1'b1;
          state <= IDLE;
        end
        J_WR: begin
          if (!j_ok) monitor_error <= 1'b1;
          if (AUTOINC) mon_a <= mon_a + ADDR_W'(1);
          monitor_ready <= 1'b1;
          state <= IDLE;
        end
        C_RD: begin
          // a strobe accepted while the CPU read finishes starts from IDLE next cycle
          pend_rd <= op_rd;
          pend_wr <= op_wr;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
